lcd_cmd_host: RTL

LCD_CMD_HOST -- requirements
Module: lcd_cmd_host

---
 rtl/lcd_cmd_host.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_host.sv
// LCD command sequencer: fetches command codes from a ROM, hands them to the LCD
// controller with busy/done handshaking, and reports completion, timeout or a missing terminator.
module lcd_cmd_host #(
  parameter int unsigned TO_LIMIT = 1023,
  parameter int unsigned ROM_AW   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cmd_rom_rd,
  output logic [ROM_AW-1:0] cmd_rom_a,
  input  logic [3:0]        cmd_rom_q,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  output logic              seq_done,
  output logic [1:0]        err,
  output logic [6:0]        cmd_count
);

  localparam int unsigned WW = $clog2(TO_LIMIT + 1);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT_RDY,
    ISSUE,
    HOLD,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH,
    ERROR
  } state_t;

  state_t        state;
  logic [3:0]    code;
  logic [WW-1:0] wait_cnt;
  logic          to_hit;
  logic          addr_max;

  // The wait that would bring the counter up to TO_LIMIT is the last one allowed.
  assign to_hit   = (wait_cnt == WW'(TO_LIMIT - 1));
  assign addr_max = &cmd_rom_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_rom_rd <= 1'b0;
      cmd_rom_a  <= '0;
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      seq_done   <= 1'b0;
      err        <= '0;
      cmd_count  <= '0;
      wait_cnt   <= '0;
      code       <= '0;
    end else begin
      cmd_rom_rd <= 1'b0;
      cmd_valid  <= 1'b0;
      case (state)
        IDLE, FINISH, ERROR: begin
          if (start) begin
            cmd_count  <= '0;
            seq_done   <= 1'b0;
            err        <= '0;
            cmd_rom_a  <= '0;
            cmd_rom_rd <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          code <= cmd_rom_q;
          if (cmd_rom_q < 4'd12) begin
            // An already-idle controller lets the ready wait collapse into this
            // cycle, keeping back-to-back issues five cycles apart.
            if (!busy) begin
              cmd       <= cmd_rom_q;
              cmd_valid <= 1'b1;
              state     <= ISSUE;
            end else begin
              wait_cnt <= '0;
              state    <= WAIT_RDY;
            end
          end else if (addr_max) begin
            err   <= 2'b10;
            state <= ERROR;
          end else begin
            cmd_rom_a  <= cmd_rom_a + 1'b1;
            cmd_rom_rd <= 1'b1;
            state      <= FETCH;
          end
        end
        WAIT_RDY: begin
          if (!busy) begin
            cmd       <= code;
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end else if (to_hit) begin
            err   <= 2'b01;
            state <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ISSUE: begin
          if (cmd_count != 7'h7f) cmd_count <= cmd_count + 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          wait_cnt <= '0;
          state    <= (code == 4'd0) ? WAIT_DONE : WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!busy) begin
            if (addr_max) begin
              err   <= 2'b10;
              state <= ERROR;
            end else begin
              cmd_rom_a  <= cmd_rom_a + 1'b1;
              cmd_rom_rd <= 1'b1;
              state      <= FETCH;
            end
          end else if (to_hit) begin
            err   <= 2'b01;
            state <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (done) begin
            seq_done <= 1'b1;
            state    <= FINISH;
          end else if (to_hit) begin
            err   <= 2'b01;
            state <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
